// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the latency-modelling memory controller:
// command/size codes, the controller FSM states and the byte-lane mask.
package mem_ctrl_pkg;

   localparam logic CMD_RD = 1'b0;
   localparam logic CMD_WR = 1'b1;

   typedef enum logic [1:0] {
      SZ_B   = 2'd0,
      SZ_H   = 2'd1,
      SZ_W   = 2'd2,
      SZ_RSV = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RD_WAIT = 2'd1,
      S_RD_RESP = 2'd2,
      S_WR_DATA = 2'd3
   } state_e;

   // Byte lanes touched by an access of the given size at a word offset.
   function automatic logic [3:0] lane_mask(
      input size_e      size,
      input logic [1:0] off
   );
      logic [3:0] m;
      case (size)
         SZ_B:    m = 4'b0001 << off;
         SZ_H:    m = 4'b0011 << off;
         SZ_W:    m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// Command queue for the memory controller: power-of-2 depth FIFO.
// Ports: push_i/push_data_i write side, pop_i/head_o read side, full_o/empty_o.
module mem_req_fifo #(
   parameter int p_WIDTH = 8,
   parameter int p_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push_i,
   input  logic [p_WIDTH-1:0] push_data_i,
   input  logic               pop_i,
   output logic [p_WIDTH-1:0] head_o,
   output logic               full_o,
   output logic               empty_o
);

   localparam int PW = $clog2(p_DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(p_DEPTH);

   logic [p_WIDTH-1:0] buf_q [p_DEPTH];
   logic [PW-1:0]      wr_ptr_q;
   logic [PW-1:0]      rd_ptr_q;
   logic [PW:0]        cnt_q;
   logic               do_push;
   logic               do_pop;

   assign full_o  = (cnt_q == FULL_CNT);
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign head_o  = buf_q[rd_ptr_q];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < p_DEPTH; i++) begin
            buf_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) begin
            buf_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= wr_ptr_q + PW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/mem_lat_ctrl.sv
// Memory controller with fixed read latency in front of a word-wide array.
// Ports: mem_* command/read/write channels, addr/rden/rddata/wren/wrstrb/wrdata array.
module mem_lat_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int p_ADDR_BITS  = 32,
   parameter int p_DATA_BITS  = 32,
   parameter int p_STRB_BITS  = p_DATA_BITS / 8,
   parameter int p_RD_LATENCY = 2,
   parameter int p_REQ_DEPTH  = 4,
   parameter int p_MEM_BYTES  = 262144
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [p_ADDR_BITS-1:0] mem_addr,
   input  logic                   mem_cmd,
   input  logic [1:0]             mem_size,
   input  logic                   mem_valid,
   output logic                   mem_ready,
   output logic                   mem_r_valid,
   input  logic                   mem_r_ready,
   output logic [p_DATA_BITS-1:0] mem_r_data,
   output logic                   mem_r_resp,
   input  logic                   mem_w_valid,
   output logic                   mem_w_ready,
   input  logic [p_STRB_BITS-1:0] mem_w_strb,
   input  logic [p_DATA_BITS-1:0] mem_w_data,
   output logic                   mem_w_resp,
   output logic [p_ADDR_BITS-1:0] addr,
   output logic                   rden,
   input  logic [p_DATA_BITS-1:0] rddata,
   output logic                   wren,
   output logic [p_STRB_BITS-1:0] wrstrb,
   output logic [p_DATA_BITS-1:0] wrdata
);

   localparam int         EW      = p_ADDR_BITS + 4;
   localparam logic [3:0] LAT_END = 4'(p_RD_LATENCY - 1);
   localparam logic [p_ADDR_BITS:0] MEM_END =
      (p_ADDR_BITS+1)'(p_MEM_BYTES);

   // Request classification at push time
   logic [3:0]             req_nbytes;
   logic [p_ADDR_BITS:0]   req_end;
   logic                   req_misal;
   logic                   req_err;

   always_comb begin
      req_nbytes = 4'd1 << mem_size;
      req_end    = {1'b0, mem_addr} + (p_ADDR_BITS+1)'(req_nbytes);
      case (size_e'(mem_size))
         SZ_H:    req_misal = mem_addr[0];
         SZ_W:    req_misal = |mem_addr[1:0];
         default: req_misal = 1'b0;
      endcase
      req_err = (size_e'(mem_size) == SZ_RSV)
             || req_misal
             || (req_end > MEM_END);
   end

   // Command queue
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   push;
   logic                   pop;
   logic [EW-1:0]          head;
   logic [p_ADDR_BITS-1:0] h_addr;
   logic                   h_cmd;
   logic [1:0]             h_size;
   logic                   h_err;
   logic [p_ADDR_BITS-1:0] h_word;

   // Gated by rst so the port reads 0 while the block is held in reset.
   assign mem_ready = rst && !fifo_full;
   assign push      = mem_valid && mem_ready;

   assign {h_addr, h_cmd, h_size, h_err} = head;
   assign h_word = {h_addr[p_ADDR_BITS-1:2], 2'b00};

   mem_req_fifo #(
      .p_WIDTH (EW),
      .p_DEPTH (p_REQ_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_data_i ({mem_addr, mem_cmd, mem_size, req_err}),
      .pop_i       (pop),
      .head_o      (head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   // Controller FSM
   state_e                 state_q;
   logic [3:0]             lat_q;
   logic [p_DATA_BITS-1:0] rbuf_q;
   logic [p_DATA_BITS-1:0] cap_data;
   logic [p_DATA_BITS-1:0] resp_data;
   logic                   r_valid_q;
   logic [p_DATA_BITS-1:0] r_data_q;
   logic                   r_resp_q;
   logic                   w_ready_q;
   logic                   w_resp_q;
   logic                   rden_q;
   logic                   wren_q;
   logic [p_ADDR_BITS-1:0] addr_q;
   logic [p_STRB_BITS-1:0] wrstrb_q;
   logic [p_DATA_BITS-1:0] wrdata_q;

   assign pop = ((state_q == S_RD_RESP) && mem_r_ready)
             || ((state_q == S_WR_DATA) && mem_w_valid);

   // rden only fires for good reads, so an error read captures 0.
   assign cap_data  = rden_q ? rddata : '0;
   // With a latency of 1 the capture and the response share a cycle.
   assign resp_data = (lat_q == '0) ? cap_data : rbuf_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         lat_q     <= '0;
         rbuf_q    <= '0;
         r_valid_q <= 1'b0;
         r_data_q  <= '0;
         r_resp_q  <= 1'b0;
         w_ready_q <= 1'b0;
         w_resp_q  <= 1'b0;
         rden_q    <= 1'b0;
         wren_q    <= 1'b0;
         addr_q    <= '0;
         wrstrb_q  <= '0;
         wrdata_q  <= '0;
      end else begin
         rden_q <= 1'b0;
         wren_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (!fifo_empty) begin
                  if (h_cmd == CMD_RD) begin
                     state_q <= S_RD_WAIT;
                     lat_q   <= '0;
                     rden_q  <= !h_err;
                     if (!h_err) begin
                        addr_q <= h_word;
                     end
                  end else begin
                     state_q   <= S_WR_DATA;
                     w_ready_q <= 1'b1;
                     w_resp_q  <= h_err;
                  end
               end
            end
            S_RD_WAIT: begin
               if (lat_q == '0) begin
                  rbuf_q <= cap_data;
               end
               if (lat_q == LAT_END) begin
                  state_q   <= S_RD_RESP;
                  r_valid_q <= 1'b1;
                  r_data_q  <= resp_data;
                  r_resp_q  <= h_err;
               end else begin
                  lat_q <= lat_q + 4'd1;
               end
            end
            S_RD_RESP: begin
               if (mem_r_ready) begin
                  state_q   <= S_IDLE;
                  r_valid_q <= 1'b0;
                  r_data_q  <= '0;
                  r_resp_q  <= 1'b0;
               end
            end
            S_WR_DATA: begin
               if (mem_w_valid) begin
                  state_q   <= S_IDLE;
                  w_ready_q <= 1'b0;
                  w_resp_q  <= 1'b0;
                  wren_q    <= !h_err;
                  if (!h_err) begin
                     addr_q   <= h_word;
                     wrdata_q <= mem_w_data;
                     wrstrb_q <= mem_w_strb
                              & lane_mask(size_e'(h_size), h_addr[1:0]);
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign mem_r_valid = r_valid_q;
   assign mem_r_data  = r_data_q;
   assign mem_r_resp  = r_resp_q;
   assign mem_w_ready = w_ready_q;
   assign mem_w_resp  = w_resp_q;
   assign rden        = rden_q;
   assign wren        = wren_q;
   assign addr        = addr_q;
   assign wrstrb      = wrstrb_q;
   assign wrdata      = wrdata_q;

endmodule

// File: tb/tb_mem_lat_ctrl.sv
// Bench for mem_lat_ctrl: vector table plus directed corner sequences,
// with a scoreboard for responses and backing-array accesses.
module tb_mem_lat_ctrl;

   localparam int L  = 3;
   localparam int MB = 262144;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] mem_addr = '0;
   logic        mem_cmd = 1'b0;
   logic [1:0]  mem_size = '0;
   logic        mem_valid = 1'b0;
   logic        mem_ready;
   logic        mem_r_valid;
   logic        mem_r_ready = 1'b0;
   logic [31:0] mem_r_data;
   logic        mem_r_resp;
   logic        mem_w_valid = 1'b0;
   logic        mem_w_ready;
   logic [3:0]  mem_w_strb = '0;
   logic [31:0] mem_w_data = '0;
   logic        mem_w_resp;
   logic [31:0] addr;
   logic        rden;
   logic [31:0] rddata;
   logic        wren;
   logic [3:0]  wrstrb;
   logic [31:0] wrdata;

   always #5 clk = ~clk;

   mem_lat_ctrl #(
      .p_RD_LATENCY (L),
      .p_REQ_DEPTH  (4),
      .p_MEM_BYTES  (MB)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_addr    (mem_addr),
      .mem_cmd     (mem_cmd),
      .mem_size    (mem_size),
      .mem_valid   (mem_valid),
      .mem_ready   (mem_ready),
      .mem_r_valid (mem_r_valid),
      .mem_r_ready (mem_r_ready),
      .mem_r_data  (mem_r_data),
      .mem_r_resp  (mem_r_resp),
      .mem_w_valid (mem_w_valid),
      .mem_w_ready (mem_w_ready),
      .mem_w_strb  (mem_w_strb),
      .mem_w_data  (mem_w_data),
      .mem_w_resp  (mem_w_resp),
      .addr        (addr),
      .rden        (rden),
      .rddata      (rddata),
      .wren        (wren),
      .wrstrb      (wrstrb),
      .wrdata      (wrdata)
   );

   // Backing array
   logic [31:0] bmem [65536];
   assign rddata = bmem[addr[17:2]];

   always @(posedge clk) begin
      if (wren) begin
         for (int b = 0; b < 4; b++) begin
            if (wrstrb[b]) bmem[addr[17:2]][8*b +: 8] <= wrdata[8*b +: 8];
         end
      end
   end

   typedef struct {
      logic        cmd;
      logic [31:0] data;
      logic        resp;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [3:0]  s;
      logic [31:0] d;
   } wr_t;

   typedef struct {
      logic        cmd;
      logic [1:0]  sz;
      logic [31:0] a;
      logic [31:0] wd;
      logic [3:0]  ws;
      logic [31:0] xd;
      logic [3:0]  xs;
      logic        xr;
   } vec_t;

   exp_t        resp_q[$];
   wr_t         wr_q[$];
   logic [31:0] rd_q[$];
   vec_t        tbl[$];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int n_rden = 0;
   int n_wren = 0;
   int n_rhs = 0;
   int n_rv = 0;
   int n_acc = 0;
   int last_rden_cyc = 0;
   int last_acc_cyc = 0;
   int first_pop_cyc = 0;
   logic arm_pop = 1'b0;
   logic prev_rv = 1'b0;
   logic hold_v = 1'b0;
   logic [31:0] held = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic bad(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      if (act !== exp) bad(nm, act, exp);
      else n_cmp++;
   endtask

   task automatic chk_zero(input string t);
      chk({t, "_r_valid"}, 32'(mem_r_valid), 0);
      chk({t, "_r_data"}, mem_r_data, 0);
      chk({t, "_r_resp"}, 32'(mem_r_resp), 0);
      chk({t, "_w_ready"}, 32'(mem_w_ready), 0);
      chk({t, "_w_resp"}, 32'(mem_w_resp), 0);
      chk({t, "_rden"}, 32'(rden), 0);
      chk({t, "_wren"}, 32'(wren), 0);
      chk({t, "_addr"}, addr, 0);
      chk({t, "_wrstrb"}, 32'(wrstrb), 0);
      chk({t, "_wrdata"}, wrdata, 0);
      chk({t, "_ready"}, 32'(mem_ready), 0);
   endtask

   // Monitor: everything sampled mid-cycle on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         prev_rv = 1'b0;
         hold_v  = 1'b0;
      end else begin
         if (rden) begin
            n_rden++;
            last_rden_cyc = cyc;
            if (rd_q.size() == 0) bad("rden_unexpected", addr, 0);
            else chk("rden_addr", addr, rd_q.pop_front());
         end
         if (wren) begin
            n_wren++;
            if (wr_q.size() == 0) begin
               bad("wren_unexpected", addr, 0);
            end else begin
               wr_t w;
               w = wr_q.pop_front();
               chk("wr_addr", addr, w.a);
               chk("wr_strb", 32'(wrstrb), 32'(w.s));
               chk("wr_data", wrdata, w.d);
            end
         end
         if (mem_r_valid && !prev_rv && resp_q.size() > 0
             && !resp_q[0].resp) begin
            chk("rd_latency", 32'(cyc - last_rden_cyc), L);
         end
         if (mem_r_valid && !mem_r_ready) begin
            if (hold_v) chk("r_hold", mem_r_data, held);
            held   = mem_r_data;
            hold_v = 1'b1;
         end else begin
            hold_v = 1'b0;
         end
         if (mem_r_valid && mem_r_ready) begin
            n_rhs++;
            if (arm_pop) begin
               first_pop_cyc = cyc;
               arm_pop = 1'b0;
               chk("ready_low_at_pop", 32'(mem_ready), 0);
            end
            if (resp_q.size() == 0) begin
               bad("r_unexpected", mem_r_data, 0);
            end else begin
               exp_t e;
               e = resp_q.pop_front();
               chk("r_data", mem_r_data, e.data);
               chk("r_resp", 32'(mem_r_resp), 32'(e.resp));
            end
         end
         if (mem_w_valid && mem_w_ready) begin
            if (resp_q.size() == 0) begin
               bad("w_unexpected", 32'(mem_w_resp), 0);
            end else begin
               exp_t e;
               e = resp_q.pop_front();
               chk("w_resp", 32'(mem_w_resp), 32'(e.resp));
            end
         end
         if (mem_r_valid) n_rv++;
         prev_rv = mem_r_valid;
      end
   end

   task automatic send_cmd(input logic c, input logic [1:0] s,
                           input logic [31:0] a, input logic [31:0] xd,
                           input logic xr);
      bit ok;
      resp_q.push_back('{c, xd, xr});
      if (!c && !xr) rd_q.push_back(a & ~32'h3);
      mem_cmd   = c;
      mem_size  = s;
      mem_addr  = a;
      mem_valid = 1'b1;
      ok = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (mem_ready) begin
            ok = 1;
            n_acc++;
            last_acc_cyc = cyc;
            break;
         end
      end
      if (!ok) bad("timeout_cmd", a, 0);
      @(posedge clk);
      #1;
      mem_valid = 1'b0;
   endtask

   task automatic send_wdata(input logic [31:0] d, input logic [3:0] s);
      bit ok;
      mem_w_data  = d;
      mem_w_strb  = s;
      mem_w_valid = 1'b1;
      ok = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (mem_w_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) bad("timeout_wdata", d, 0);
      @(posedge clk);
      #1;
      mem_w_valid = 1'b0;
   endtask

   task automatic drain();
      bit ok;
      ok = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (resp_q.size() == 0 && wr_q.size() == 0) begin
            ok = 1;
            break;
         end
      end
      if (!ok) bad("timeout_drain", 32'(resp_q.size()), 0);
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(logic c, logic [1:0] sz, logic [31:0] a,
                               logic [31:0] wd, logic [3:0] ws,
                               logic [31:0] xd, logic [3:0] xs,
                               logic xr);
      vec_t v;
      v = '{c, sz, a, wd, ws, xd, xs, xr};
      return v;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int   r0;
      int   w0;
      int   h0;
      int   a0;
      int   v0;
      bit   ok;

      for (int i = 0; i < 65536; i++) bmem[i] = '0;
      bmem['h100 >> 2] = 32'hDEADBEEF;

      // cmd sz addr wdata wstrb exp_data exp_strb exp_resp
      tbl.push_back(mk(0, 2, 'h100, 0, 0, 'hDEADBEEF, 0, 0));
      tbl.push_back(mk(1, 1, 'h102, 'h12345678, 'hF, 0, 'b1100, 0));
      tbl.push_back(mk(0, 2, 'h100, 0, 0, 'h1234BEEF, 0, 0));
      tbl.push_back(mk(0, 2, 'h101, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 2, MB, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 0, 'h201, 'hAABBCCDD, 'hF, 0, 'b0010, 0));
      tbl.push_back(mk(0, 0, 'h201, 0, 0, 'h0000CC00, 0, 0));
      tbl.push_back(mk(1, 2, 'h204, 'h11223344, 'b0101, 0, 'b0101, 0));
      tbl.push_back(mk(0, 1, 'h206, 0, 0, 'h00220044, 0, 0));
      tbl.push_back(mk(1, 1, 'h203, 'hFFFFFFFF, 'hF, 0, 0, 1));
      tbl.push_back(mk(0, 3, 'h200, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 2, 'h200, 0, 0, 'h0000CC00, 0, 0));
      tbl.push_back(mk(1, 2, 'h3FFFC, 'hCAFEF00D, 'hF, 0, 'hF, 0));
      tbl.push_back(mk(0, 2, 'h3FFFC, 0, 0, 'hCAFEF00D, 0, 0));
      tbl.push_back(mk(0, 1, 'h3FFFE, 0, 0, 'hCAFEF00D, 0, 0));
      tbl.push_back(mk(0, 0, 'h3FFFF, 0, 0, 'hCAFEF00D, 0, 0));
      tbl.push_back(mk(0, 2, 'h3FFFE, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 1, 'h3FFFF, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 2, MB, 'h55555555, 'hF, 0, 0, 1));
      tbl.push_back(mk(1, 1, 'h3FFFF, 'h66666666, 'hF, 0, 0, 1));
      tbl.push_back(mk(0, 2, 'h3FFFC, 0, 0, 'hCAFEF00D, 0, 0));

      // Reset state
      #2;
      chk_zero("rst0");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("ready_after_rst", 32'(mem_ready), 1);
      @(posedge clk);
      #1;

      // Vector table
      mem_r_ready = 1'b1;
      foreach (tbl[i]) begin
         v  = tbl[i];
         r0 = n_rden;
         w0 = n_wren;
         if (v.cmd && !v.xr) wr_q.push_back('{v.a & ~32'h3, v.xs, v.wd});
         send_cmd(v.cmd, v.sz, v.a, v.xd, v.xr);
         if (v.cmd) send_wdata(v.wd, v.ws);
         drain();
         chk("n_rden", 32'(n_rden - r0), 32'(!v.cmd && !v.xr));
         chk("n_wren", 32'(n_wren - w0), 32'(v.cmd && !v.xr));
      end

      // Write data presented while idle is ignored
      w0 = n_wren;
      mem_w_data  = 32'hBAD0BAD0;
      mem_w_strb  = 4'hF;
      mem_w_valid = 1'b1;
      repeat (6) begin
         @(negedge clk);
         chk("idle_w_ready", 32'(mem_w_ready), 0);
      end
      @(posedge clk);
      #1;
      mem_w_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_no_wren", 32'(n_wren - w0), 0);
      @(posedge clk);
      #1;

      // Five back-to-back reads with the response channel stalled
      mem_r_ready = 1'b0;
      a0 = n_acc;
      fork
         begin
            send_cmd(0, 2, 'h100, 'h1234BEEF, 0);
            send_cmd(0, 2, 'h200, 'h0000CC00, 0);
            send_cmd(0, 2, 'h204, 'h00220044, 0);
            send_cmd(0, 2, 'h101, 0, 1);
            send_cmd(0, 2, 'h3FFFC, 'hCAFEF00D, 0);
         end
         begin
            ok = 0;
            for (int k = 0; k < 50; k++) begin
               @(negedge clk);
               if (n_acc >= a0 + 4) begin
                  ok = 1;
                  break;
               end
            end
            if (!ok) bad("timeout_fill", 32'(n_acc - a0), 4);
            repeat (4) begin
               @(negedge clk);
               chk("full_ready_low", 32'(mem_ready), 0);
            end
            chk("accepts_when_full", 32'(n_acc - a0), 4);
            @(posedge clk);
            #1;
            arm_pop = 1'b1;
            mem_r_ready = 1'b1;
         end
      join
      chk("acc5_after_pop", 32'(last_acc_cyc), 32'(first_pop_cyc + 1));
      drain();

      // Response held through a 10-cycle stall, popped once
      mem_r_ready = 1'b0;
      send_cmd(0, 2, 'h204, 'h00220044, 0);
      ok = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (mem_r_valid) begin
            ok = 1;
            break;
         end
      end
      if (!ok) bad("timeout_rvalid", 0, 1);
      h0 = n_rhs;
      repeat (10) begin
         @(negedge clk);
         chk("stall_r_valid", 32'(mem_r_valid), 1);
         chk("stall_r_data", mem_r_data, 'h00220044);
      end
      @(posedge clk);
      #1;
      mem_r_ready = 1'b1;
      drain();
      repeat (5) @(negedge clk);
      chk("stall_one_pop", 32'(n_rhs - h0), 1);
      @(posedge clk);
      #1;

      // Reset in the middle of RD_WAIT
      r0 = n_rden;
      send_cmd(0, 2, 'h100, 'h1234BEEF, 0);
      ok = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (n_rden != r0) begin
            ok = 1;
            break;
         end
      end
      if (!ok) bad("timeout_rden", 0, 1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk_zero("rst_mid");
      resp_q.delete();
      rd_q.delete();
      wr_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b1;
      v0 = n_rv;
      repeat (10) @(negedge clk);
      chk("no_rvalid_after_rst", 32'(n_rv - v0), 0);
      chk("ready_after_mid_rst", 32'(mem_ready), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_lat_ctrl.md
MEM_LAT_CTRL -- requirements
Module: mem_lat_ctrl

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
  p_ADDR_BITS, 32, byte-address width.
  p_DATA_BITS, 32, data width; only 32 is supported.
  p_STRB_BITS, p_DATA_BITS/8, byte-strobe width.
  p_RD_LATENCY, 2, cycles from rden to mem_r_valid; valid range 1..15.
  p_REQ_DEPTH, 4, command queue entries; must be a power of 2, at least 2.
  p_MEM_BYTES, 262144, size of the backing array in bytes.
REQ-002 Ports SHALL be as follows, one per line: name, direction, width, meaning.
  clk  in  1  clock.
  rst  in  1  asynchronous, active-low reset.
  mem_addr  in  p_ADDR_BITS  request byte address.
  mem_cmd  in  1  0 = read, 1 = write.
  mem_size  in  2  0 = byte, 1 = half-word, 2 = word, 3 = reserved.
  mem_valid / mem_ready  in / out  1  command handshake.
  mem_r_valid / mem_r_ready  out / in  1  read-response handshake.
  mem_r_data  out  p_DATA_BITS  read data (word lane).
  mem_r_resp  out  1  1 = read error.
  mem_w_valid / mem_w_ready  in / out  1  write-data handshake.
  mem_w_strb  in  p_STRB_BITS  write byte strobes.
  mem_w_data  in  p_DATA_BITS  write data.
  mem_w_resp  out  1  1 = write error; valid during the write-data handshake cycle.
  addr  out  p_ADDR_BITS  backing-array address.
  rden  out  1  backing-array read enable.
  rddata  in  p_DATA_BITS  backing-array read data, combinational from addr.
  wren  out  1  backing-array write enable.
  wrstrb  out  p_STRB_BITS  backing-array byte strobes.
  wrdata  out  p_DATA_BITS  backing-array write data.

Function
REQ-003 A command SHALL be accepted on mem_valid && mem_ready and pushed into a FIFO of p_REQ_DEPTH entries; mem_ready SHALL equal !full, taken from the registered count.
REQ-004 When the FIFO is full, mem_ready SHALL stay low even in a cycle where the head entry retires; the freed slot SHALL become available the next cycle.
REQ-005 Each entry SHALL carry addr, cmd, size, and an err flag computed at push.
REQ-006 err SHALL be set for any of the following:
  size == 3;
  misalignment: for half-word, addr[0] != 0; for word, addr[1:0] != 0;
  addr + (1 << size) > p_MEM_BYTES.
REQ-007 Commands SHALL complete strictly in order, with one command in service at a time.
REQ-008 The FSM SHALL have states IDLE, RD_WAIT, RD_RESP, and WR_DATA.
REQ-009 IDLE behaviour: when the FIFO is non-empty, go to RD_WAIT for a read head or WR_DATA for a write head.
REQ-010 On entering RD_WAIT from a non-error read, rden SHALL pulse for exactly 1 cycle with addr = {head.addr[p_ADDR_BITS-1:2], 2'b00}; rddata SHALL be captured in that same cycle.
REQ-011 A read with err set SHALL not assert rden and SHALL capture data 0.
REQ-012 RD_WAIT SHALL count p_RD_LATENCY-1 further cycles and then enter RD_RESP, so that mem_r_valid rises exactly p_RD_LATENCY cycles after the issue cycle.
REQ-013 In RD_RESP, mem_r_valid, mem_r_data, and mem_r_resp SHALL be held stable until mem_r_ready; on that handshake the entry is popped and the FSM returns to IDLE.
REQ-014 In WR_DATA, mem_w_ready SHALL be 1 and in every other state it SHALL be 0.
REQ-015 On mem_w_valid && mem_w_ready:
  for a non-error entry, wren SHALL pulse for 1 cycle with wrdata = mem_w_data and wrstrb = mem_w_strb & lane_mask(size, addr[1:0]);
  for an error entry, wren SHALL stay 0;
  mem_w_resp SHALL equal err in that cycle;
  the entry SHALL be popped and the FSM SHALL return to IDLE.
REQ-016 lane_mask SHALL be 4'b0001 << addr[1:0] for byte, 4'b0011 << addr[1:0] for half-word, and 4'b1111 for word.
REQ-017 A push and a pop in the same cycle SHALL leave the count unchanged; pointers SHALL wrap modulo p_REQ_DEPTH.
REQ-018 mem_w_valid asserted outside WR_DATA SHALL be ignored and SHALL cause no wren.

Reset
REQ-019 rst low SHALL asynchronously clear the FIFO, the pointers, the count, the latency counter, and the FSM (to IDLE), including mid-operation; any captured read data SHALL be dropped.
REQ-020 Reset values SHALL be: mem_ready = 0 while rst is low and 1 after release; all of mem_r_valid, mem_r_data, mem_r_resp, mem_w_ready, mem_w_resp, rden, wren, addr, wrstrb, and wrdata = 0.

Structure
REQ-021 Package mem_ctrl_pkg SHALL hold the cmd and size encodings, the FSM state enum, and the lane_mask function.
REQ-022 The FIFO SHALL be the sub-module mem_req_fifo, parametrised by width and depth.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
  Word read, p_RD_LATENCY = 3, addr 0x100 holding 0xDEADBEEF: rden at T, mem_r_valid at T+3 with data 0xDEADBEEF and resp 0.
  Half-word write to 0x102 with mem_w_strb 4'hF, data 0x1234_5678: wren with wrstrb 4'b1100; mem_w_resp 0.
  Misaligned word read at 0x101 and read at p_MEM_BYTES: no rden; mem_r_resp 1; data 0.
  Five back-to-back commands with p_REQ_DEPTH = 4 and mem_r_ready held low: mem_ready falls after 4 accepts; the 5th is accepted the cycle after the first pop; in-order responses.
  mem_r_valid held with mem_r_ready stalled for 10 cycles: data stable; exactly one pop.
  rst pulsed low during RD_WAIT: all outputs 0 immediately; no mem_r_valid after release.
